// File: rtl/ms_arbiter.sv
// Two-port arbiter in front of the single-port main store: CPU datapath (C) and
// debug/loader (D). One access at a time, IDLE -> SERVE -> RESP, optional D lock.
module ms_arbiter #(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 8,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ms_read,
    output logic              ms_write,
    output logic [ADDR_W-1:0] ms_addr,
    output logic [DATA_W-1:0] ms_wdata,
    input  logic [DATA_W-1:0] ms_rdata,
    output logic              cpu_hold
);

    localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    state_t            state, state_nxt;
    logic              own_d, own_d_nxt;    // 1: D owns the in-flight access
    logic              last_d, last_d_nxt;  // 1: most recent grant went to D
    logic [7:0]        lock_cnt, lock_cnt_nxt;
    logic              grant, grant_d;
    logic              lock_ok;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
    logic              hold_q;
    logic              serve, resp;

    assign lock_ok = last_d & d_lock & d_req & (lock_cnt < LOCK_LIM);

    always_comb begin
        state_nxt    = state;
        own_d_nxt    = own_d;
        last_d_nxt   = last_d;
        lock_cnt_nxt = lock_cnt;
        grant        = 1'b0;
        grant_d      = 1'b0;
        case (state)
            IDLE: begin
                if (c_req || d_req) begin
                    grant = 1'b1;
                    // Contention: a D lock holds the store, otherwise round-robin.
                    if (c_req && d_req) grant_d = lock_ok | ~last_d;
                    else                grant_d = d_req;
                    state_nxt  = SERVE;
                    own_d_nxt  = grant_d;
                    last_d_nxt = grant_d;
                end
            end
            SERVE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Only D grants taken while C is waiting eat into the lock budget.
        if (!d_lock)
            lock_cnt_nxt = '0;
        else if (grant && !grant_d)
            lock_cnt_nxt = '0;
        else if (grant && grant_d && c_req && lock_cnt < LOCK_LIM)
            lock_cnt_nxt = lock_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            own_d     <= 1'b0;
            last_d    <= 1'b1;
            lock_cnt  <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
            hold_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            own_d    <= own_d_nxt;
            last_d   <= last_d_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (grant) begin
                lat_write <= grant_d ? d_write : c_write;
                lat_addr  <= grant_d ? d_addr  : c_addr;
                lat_wdata <= grant_d ? d_wdata : c_wdata;
            end
            if (c_ack && !lat_write) c_rdata_q <= ms_rdata;
            if (d_ack && !lat_write) d_rdata_q <= ms_rdata;
            hold_q <= (c_req & ~c_ack) | ((state_nxt != IDLE) & own_d_nxt);
        end
    end

    assign serve    = (state == SERVE);
    assign resp     = (state == RESP);
    assign ms_read  = serve & ~lat_write;
    assign ms_write = serve & lat_write;
    assign ms_addr  = serve ? lat_addr : '0;
    assign ms_wdata = ms_write ? lat_wdata : '0;
    assign c_ack    = resp & ~own_d;
    assign d_ack    = resp & own_d;
    // The store registers data_o during SERVE, so read data is live in RESP.
    assign c_rdata  = (c_ack & ~lat_write) ? ms_rdata : c_rdata_q;
    assign d_rdata  = (d_ack & ~lat_write) ? ms_rdata : d_rdata_q;
    assign cpu_hold = hold_q;

    ack_excl: assert property (@(posedge clk) disable iff (rst) !(c_ack && d_ack));
    strb_excl: assert property (@(posedge clk) disable iff (rst) !(ms_read && ms_write));

endmodule
